// File: rtl/busca_instrucao.sv
// Instruction fetch: holds the PC, fetches with one request in flight, and buffers up to 2 instructions for decode.
// Ports: clk/rst_n; endProx/redireciona come from the next-PC selector, and endAtual (pc+4) goes back to it;
//        mem_* is the request/grant plus response-valid handshake; instr* is the valid/ready queue head toward decode.
module busca_instrucao #(
  parameter int                 LARGURA   = 32,
  parameter logic [LARGURA-1:0] END_RESET = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] endProx,
  input  logic               redireciona,
  output logic [LARGURA-1:0] endAtual,
  output logic               mem_req,
  output logic [LARGURA-1:0] mem_end,
  input  logic               mem_pronto,
  input  logic [LARGURA-1:0] mem_dado,
  input  logic               mem_valido,
  output logic [LARGURA-1:0] instr,
  output logic [LARGURA-1:0] instr_pc,
  output logic               instr_valido,
  input  logic               instr_pronto
);

  typedef enum logic [1:0] {
    BUSCA  = 2'd0,
    ESPERA = 2'd1,
    CHEIO  = 2'd2
  } estado_t;

  localparam logic [LARGURA-1:0] QUATRO = LARGURA'(4);

  estado_t            estado, estado_prox;
  logic [LARGURA-1:0] pc;
  logic [LARGURA-1:0] end_busca;   // address of the request in flight, used to tag its response
  logic               descarte, descarte_prox;

  // second queue slot; the head lives directly in instr/instr_pc/instr_valido
  logic [LARGURA-1:0] seg_dado;
  logic [LARGURA-1:0] seg_pc;
  logic               seg_valido;

  logic       aceito;
  logic       push;
  logic       pop;
  logic [1:0] conta;
  logic [1:0] conta_apos;

  assign endAtual = pc + QUATRO;
  assign mem_end  = pc;

  // Gating with rst_n keeps the request low for as long as reset is held.
  // Gating with redireciona keeps a stale address from being granted.
  assign mem_req = rst_n & (estado == BUSCA) & ~redireciona;
  assign aceito  = mem_req & mem_pronto;
  assign pop     = instr_valido & instr_pronto;
  assign push    = (estado == ESPERA) & mem_valido & ~descarte;

  assign conta      = {1'b0, instr_valido} + {1'b0, seg_valido};
  assign conta_apos = conta + 2'(push) - 2'(pop);

  always_comb begin
    estado_prox   = estado;
    descarte_prox = descarte;
    if (redireciona) begin
      // An outstanding fetch must be absorbed before fetching again, unless it is arriving right now.
      if (estado == ESPERA && !mem_valido) begin
        estado_prox   = ESPERA;
        descarte_prox = 1'b1;
      end else begin
        estado_prox   = BUSCA;
        descarte_prox = 1'b0;
      end
    end else begin
      unique case (estado)
        BUSCA: begin
          if (aceito) estado_prox = ESPERA;
        end
        ESPERA: begin
          if (mem_valido) begin
            descarte_prox = 1'b0;
            estado_prox   = (push && conta_apos == 2'd2) ? CHEIO : BUSCA;
          end
        end
        CHEIO: begin
          if (pop) estado_prox = BUSCA;
        end
        default: estado_prox = BUSCA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= BUSCA;
      descarte  <= 1'b0;
      pc        <= END_RESET;
      end_busca <= END_RESET;
    end else begin
      estado   <= estado_prox;
      descarte <= descarte_prox;
      if (redireciona) begin
        pc <= {endProx[LARGURA-1:2], 2'b00};
      end else if (aceito) begin
        pc        <= pc + QUATRO;
        end_busca <= pc;
      end
    end
  end

  // Two-entry queue. The head is filled first, so seg_valido implies instr_valido.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr        <= '0;
      instr_pc     <= '0;
      instr_valido <= 1'b0;
      seg_dado     <= '0;
      seg_pc       <= '0;
      seg_valido   <= 1'b0;
    end else if (redireciona) begin
      instr_valido <= 1'b0;
      seg_valido   <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (!instr_valido) begin
            instr        <= mem_dado;
            instr_pc     <= end_busca;
            instr_valido <= 1'b1;
          end else begin
            seg_dado   <= mem_dado;
            seg_pc     <= end_busca;
            seg_valido <= 1'b1;
          end
        end
        2'b01: begin
          if (seg_valido) begin
            instr      <= seg_dado;
            instr_pc   <= seg_pc;
            seg_valido <= 1'b0;
          end else begin
            instr_valido <= 1'b0;
          end
        end
        2'b11: begin
          if (seg_valido) begin
            instr    <= seg_dado;
            instr_pc <= seg_pc;
            seg_dado <= mem_dado;
            seg_pc   <= end_busca;
          end else begin
            instr    <= mem_dado;
            instr_pc <= end_busca;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Testbench for busca_instrucao: directed steps with a scripted memory model.
// Expected deliveries are queued by each step and compared at every decode handshake.
module tb_busca_instrucao;

  logic        clk;
  logic        rst_n;
  logic [31:0] endProx;
  logic        redireciona;
  logic [31:0] endAtual;
  logic        mem_req;
  logic [31:0] mem_end;
  logic        mem_pronto;
  logic [31:0] mem_dado;
  logic        mem_valido;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valido;
  logic        instr_pronto;

  busca_instrucao #(.LARGURA(32), .END_RESET(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .endProx      (endProx),
    .redireciona  (redireciona),
    .endAtual     (endAtual),
    .mem_req      (mem_req),
    .mem_end      (mem_end),
    .mem_pronto   (mem_pronto),
    .mem_dado     (mem_dado),
    .mem_valido   (mem_valido),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valido (instr_valido),
    .instr_pronto (instr_pronto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          testes = 0;
  int          falhas = 0;
  logic [31:0] esperado[$];

  // memory model state
  logic        pend;
  logic [31:0] pend_end;
  int          espera;   // extra cycles before the pending response
  int          lat;      // extra response latency applied to the next grant
  int          atraso;   // cycles of mem_pronto=0 while mem_req is high

  int t1_vld [7] = '{0, 0, 1, 0, 1, 0, 1};
  int t1_req [7] = '{1, 0, 1, 0, 1, 0, 1};

  function automatic logic [31:0] dado_de(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    testes++;
    assert (obs === esp) else begin
      falhas++;
      $error("FAIL %s: observed %h expected %h", tag, obs, esp);
    end
  endtask

  // Drive memory outputs for this cycle and let combinational outputs settle.
  task automatic prep();
    mem_valido = pend && (espera == 0);
    mem_dado   = mem_valido ? dado_de(pend_end) : 32'h0;
    mem_pronto = (atraso == 0);
    #1;
  endtask

  // Scoreboard check at the handshake, memory model bookkeeping, and advance to the next negedge.
  task automatic fim();
    logic [31:0] e;
    if (instr_valido && instr_pronto && !redireciona && rst_n) begin
      testes++;
      assert (esperado.size() != 0) else begin
        falhas++;
        $error("FAIL sb_inesperado: observed instr_pc %h expected no delivery", instr_pc);
      end
      if (esperado.size() != 0) begin
        e = esperado.pop_front();
        chk("sb_instr_pc", instr_pc, e);
        chk("sb_instr", instr, dado_de(e));
      end
    end
    if (mem_valido) pend = 1'b0;
    else if (pend && espera > 0) espera--;
    if (mem_req && mem_pronto) begin
      pend     = 1'b1;
      pend_end = mem_end;
      espera   = lat;
    end else if (mem_req && atraso > 0) begin
      atraso--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ciclo();
    prep();
    fim();
  endtask

  task automatic fim_teste(input string tag);
    chk(tag, 32'(esperado.size()), 32'd0);
  endtask

  task automatic reinicia();
    rst_n = 1'b0; redireciona = 1'b0; endProx = 32'h0; instr_pronto = 1'b0;
    mem_pronto = 1'b0; mem_valido = 1'b0; mem_dado = 32'h0;
    pend = 1'b0; pend_end = 32'h0; espera = 0; lat = 0; atraso = 0;
    esperado.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_instr_valido", 32'(instr_valido), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_end", mem_end, 32'h0);
    chk("rst_endAtual", endAtual, 32'h4);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: streaming with an immediate memory, one instruction every 2 cycles
    reinicia();
    instr_pronto = 1'b1;
    esperado.push_back(32'h0); esperado.push_back(32'h4); esperado.push_back(32'h8);
    for (int c = 0; c < 7; c++) begin
      prep();
      if (c == 0) begin
        chk("t1_endAtual", endAtual, 32'h4);
        chk("t1_mem_end", mem_end, 32'h0);
      end
      chk($sformatf("t1_vld_c%0d", c), 32'(instr_valido), t1_vld[c]);
      chk($sformatf("t1_req_c%0d", c), 32'(mem_req), t1_req[c]);
      fim();
    end
    instr_pronto = 1'b0;
    fim_teste("t1_sb_vazio");

    // 2: decode stalled, queue fills to 2 and fetching stops
    reinicia();
    esperado.push_back(32'h0);
    for (int c = 0; c < 4; c++) ciclo();
    for (int c = 4; c < 6; c++) begin
      prep();
      chk("t2_cheio_req", 32'(mem_req), 32'd0);
      chk("t2_cheio_vld", 32'(instr_valido), 32'd1);
      chk("t2_cheio_pc", instr_pc, 32'h0);
      fim();
    end
    instr_pronto = 1'b1;
    prep();
    chk("t2_pop_req", 32'(mem_req), 32'd0);
    fim();
    instr_pronto = 1'b0;
    prep();
    chk("t2_cabeca_pc", instr_pc, 32'h4);
    chk("t2_cabeca_instr", instr, dado_de(32'h4));
    chk("t2_cabeca_vld", 32'(instr_valido), 32'd1);
    chk("t2_req_8", 32'(mem_req), 32'd1);
    chk("t2_end_8", mem_end, 32'h8);
    fim();
    fim_teste("t2_sb_vazio");

    // 3: redirect in BUSCA with one entry queued
    reinicia();
    ciclo(); ciclo();
    redireciona = 1'b1; endProx = 32'h0000_0040;
    prep();
    chk("t3_vld_antes", 32'(instr_valido), 32'd1);
    chk("t3_req_redir", 32'(mem_req), 32'd0);
    fim();
    redireciona = 1'b0;
    prep();
    chk("t3_vld_flush", 32'(instr_valido), 32'd0);
    chk("t3_end_40", mem_end, 32'h40);
    chk("t3_req_40", 32'(mem_req), 32'd1);
    fim();
    ciclo();
    esperado.push_back(32'h40);
    instr_pronto = 1'b1;
    prep();
    chk("t3_vld_40", 32'(instr_valido), 32'd1);
    fim();
    instr_pronto = 1'b0;
    fim_teste("t3_sb_vazio");

    // 4: redirect in ESPERA, the outstanding response is dropped
    reinicia();
    instr_pronto = 1'b1;
    esperado.push_back(32'h0); esperado.push_back(32'h4); esperado.push_back(32'h80);
    for (int c = 0; c < 4; c++) ciclo();
    lat = 1;
    prep();
    chk("t4_end_8", mem_end, 32'h8);
    chk("t4_req_8", 32'(mem_req), 32'd1);
    fim();
    lat = 0;
    redireciona = 1'b1; endProx = 32'h80;
    prep();
    chk("t4_req_redir", 32'(mem_req), 32'd0);
    fim();
    redireciona = 1'b0;
    prep();
    chk("t4_req_descarte", 32'(mem_req), 32'd0);
    chk("t4_vld_descarte", 32'(instr_valido), 32'd0);
    fim();
    prep();
    chk("t4_req_80", 32'(mem_req), 32'd1);
    chk("t4_end_80", mem_end, 32'h80);
    chk("t4_vld_sem_8", 32'(instr_valido), 32'd0);
    fim();
    ciclo();
    prep();
    chk("t4_vld_80", 32'(instr_valido), 32'd1);
    fim();
    instr_pronto = 1'b0;
    fim_teste("t4_sb_vazio");

    // 5: unaligned redirect target and a memory that withholds the grant
    reinicia();
    instr_pronto = 1'b1;
    esperado.push_back(32'h40);
    redireciona = 1'b1; endProx = 32'h0000_0043; atraso = 3;
    prep();
    chk("t5_req_redir", 32'(mem_req), 32'd0);
    fim();
    redireciona = 1'b0;
    for (int c = 1; c < 5; c++) begin
      prep();
      if (c == 1) chk("t5_endAtual", endAtual, 32'h44);
      chk($sformatf("t5_req_c%0d", c), 32'(mem_req), 32'd1);
      chk($sformatf("t5_end_c%0d", c), mem_end, 32'h40);
      fim();
    end
    ciclo();
    prep();
    chk("t5_vld_40", 32'(instr_valido), 32'd1);
    fim();
    instr_pronto = 1'b0;
    fim_teste("t5_sb_vazio");

    // 6: PC wrap, then reset pulsed while a fetch is outstanding
    reinicia();
    esperado.push_back(32'hFFFF_FFFC); esperado.push_back(32'h0);
    redireciona = 1'b1; endProx = 32'hFFFF_FFFC;
    ciclo();
    redireciona = 1'b0;
    prep();
    chk("t6_endAtual_wrap", endAtual, 32'h0);
    chk("t6_end_fffc", mem_end, 32'hFFFF_FFFC);
    chk("t6_req_fffc", 32'(mem_req), 32'd1);
    fim();
    prep();
    chk("t6_end_wrap", mem_end, 32'h0);
    chk("t6_req_espera", 32'(mem_req), 32'd0);
    fim();
    lat = 1; instr_pronto = 1'b1;
    prep();
    chk("t6_vld_fffc", 32'(instr_valido), 32'd1);
    chk("t6_req_0", 32'(mem_req), 32'd1);
    chk("t6_end_0", mem_end, 32'h0);
    fim();
    lat = 0; instr_pronto = 1'b0;
    prep();
    chk("t6_req_espera2", 32'(mem_req), 32'd0);
    chk("t6_end_4", mem_end, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(instr_valido), 32'd0);
    chk("t6_rst_end", mem_end, 32'h0);
    chk("t6_rst_req", 32'(mem_req), 32'd0);
    chk("t6_rst_endAtual", endAtual, 32'h4);
    fim();
    rst_n = 1'b1; atraso = 1;
    prep();
    chk("t6_stale_req", 32'(mem_req), 32'd1);
    chk("t6_stale_end", mem_end, 32'h0);
    fim();
    prep();
    chk("t6_stale_vld1", 32'(instr_valido), 32'd0);
    chk("t6_refetch_req", 32'(mem_req), 32'd1);
    fim();
    prep();
    chk("t6_stale_vld2", 32'(instr_valido), 32'd0);
    fim();
    instr_pronto = 1'b1;
    prep();
    chk("t6_vld_0", 32'(instr_valido), 32'd1);
    fim();
    instr_pronto = 1'b0;
    fim_teste("t6_sb_vazio");

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
